// File: rtl/cache_fill_ctrl_pkg.sv
// cache_fill_ctrl_pkg: shared constants and FSM state encoding for the cache fill controller
package cache_fill_ctrl_pkg;
  localparam int BLOCK_WORDS = 8;
  localparam int ADDR_W = 16;
  localparam int OFFSET_BITS = 4;
  localparam int WORD_IDX_W = 3;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;
endpackage

// File: rtl/cache_fill_ctrl_fill_cnt.sv
// fill_cnt: sync-clear enabled up-counter that saturates at LIMIT and flags it
module fill_cnt #(
  parameter int LIMIT = 8,
  localparam int W = $clog2(LIMIT) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         done
);
  assign done = cnt == W'(LIMIT);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en && !done) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-handling FSM that fetches a whole cache block from pipelined memory
module cache_fill_ctrl #(
  parameter int BLOCK_WORDS = cache_fill_ctrl_pkg::BLOCK_WORDS,
  parameter int ADDR_W = cache_fill_ctrl_pkg::ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           miss_detected,
  input  logic [ADDR_W-1:0]              miss_address,
  input  logic                           memory_data_valid,
  output logic                           fsm_busy,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              memory_address,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
  output logic                           write_tag_array
);
  import cache_fill_ctrl_pkg::*;
  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int CW = IW + 1;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic issue_done, recv_done, fill;
  assign fill = state == FILL;
  fill_cnt #(.LIMIT(BLOCK_WORDS)) u_issue (
    .clk(clk), .rst_n(rst_n), .clr(!fill), .en(mem_rd_en), .cnt(issue_cnt), .done(issue_done)
  );
  fill_cnt #(.LIMIT(BLOCK_WORDS)) u_recv (
    .clk(clk), .rst_n(rst_n), .clr(!fill), .en(write_data_array), .cnt(recv_cnt), .done(recv_done)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_n;
      if (!fill && miss_detected) base <= miss_address & ~ADDR_W'(2 * BLOCK_WORDS - 1);
    end
  // base has a zero offset nibble, so OR-ing in the word offset never carries into tag/index
  always_comb begin
    mem_rd_en        = fill & ~issue_done;
    write_data_array = fill & memory_data_valid & ~recv_done;
    write_tag_array  = write_data_array & (recv_cnt == CW'(BLOCK_WORDS - 1));
    fsm_busy         = fill | miss_detected;
    memory_address   = mem_rd_en ? (base | ADDR_W'({issue_cnt, 1'b0})) : base;
    word_idx         = fill ? recv_cnt[IW-1:0] : '0;
    state_n          = fill ? (write_tag_array ? IDLE : FILL) : (miss_detected ? FILL : IDLE);
  end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: table-driven basic fill plus scoreboarded corner-case sequences
module tb_cache_fill_ctrl;
  localparam int BW = 8;
  localparam int LAT = 4;
  logic clk = 0, rst_n = 0, miss_detected = 0, memory_data_valid = 0;
  logic [15:0] miss_address = '0;
  logic fsm_busy, mem_rd_en, write_data_array, write_tag_array;
  logic [15:0] memory_address;
  logic [2:0] word_idx;
  int checks = 0, errors = 0, cyc = 0, hold = 0, ret_n = 0, tag_cnt = 0;
  bit gap = 0;
  logic [15:0] addr_q[$];
  int idx_q[$];
  int due_q[$];
  typedef struct {
    logic miss; logic [15:0] addr; logic valid;
    logic busy; logic rd; logic [15:0] maddr; logic ac;
    logic wr; logic [2:0] idx; logic ic; logic tag;
  } vec_t;
  vec_t tbl[14];
  cache_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy), .mem_rd_en(mem_rd_en),
    .memory_address(memory_address), .write_data_array(write_data_array),
    .word_idx(word_idx), .write_tag_array(write_tag_array)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic drive(input logic m, input logic [15:0] a, input logic r, input logic v);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = r;
    miss_detected = m;
    miss_address = a;
    memory_data_valid = v;
    @(negedge clk);
  endtask
  task automatic observe();
    if (mem_rd_en) begin
      due_q.push_back(cyc + LAT);
      if (addr_q.size() == 0) chk("rd_extra", 1, 0);
      else chk("rd_addr", memory_address, addr_q.pop_front());
    end
    if (write_data_array) begin
      if (idx_q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        int e = idx_q.pop_front();
        chk("word_idx", word_idx, e);
        chk("tag_on_last", write_tag_array, e == BW - 1);
      end
    end else if (write_tag_array) chk("tag_alone", 1, 0);
    if (write_tag_array) tag_cnt++;
  endtask
  task automatic run(input logic m, input logic [15:0] a, input logic r, input logic spur);
    logic v = 0;
    if (hold > 0) hold--;
    else if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
      v = 1;
      void'(due_q.pop_front());
      ret_n++;
      if (gap && ret_n == 3) hold = 2;
    end
    drive(m, a, r, v | spur);
    observe();
  endtask
  task automatic start(input logic [15:0] a);
    logic [15:0] b = a & 16'hFFF0;
    ret_n = 0;
    hold = 0;
    for (int i = 0; i < BW; i++) begin
      addr_q.push_back(b + 16'(2 * i));
      idx_q.push_back(i);
    end
    run(1, a, 1, 0);
    chk("busy_start", fsm_busy, 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40 && (addr_q.size() || idx_q.size() || fsm_busy); i++) run(0, 16'h0, 1, 0);
    chk("drained", 32'(addr_q.size() + idx_q.size()), 0);
    chk("busy_end", fsm_busy, 0);
  endtask
  task automatic flush();
    addr_q.delete();
    idx_q.delete();
    due_q.delete();
    hold = 0;
    ret_n = 0;
  endtask
  initial begin
    int t0;
    for (int c = 0; c < 14; c++) begin
      tbl[c].miss = c == 0;
      tbl[c].addr = c == 0 ? 16'h1236 : 16'h0;
      tbl[c].valid = c >= 5 && c <= 12;
      tbl[c].busy = c <= 12;
      tbl[c].rd = c >= 1 && c <= 8;
      tbl[c].maddr = tbl[c].rd ? 16'h1230 + 16'(2 * (c - 1)) : 16'h1230;
      tbl[c].ac = c >= 1 && c <= 12;
      tbl[c].wr = tbl[c].valid;
      tbl[c].idx = tbl[c].wr ? 3'(c - 5) : 3'd0;
      tbl[c].ic = tbl[c].wr || c == 0 || c == 13;
      tbl[c].tag = c == 12;
    end
    drive(0, 16'h0, 0, 0);
    drive(0, 16'h0, 0, 0);
    chk("rst_busy", fsm_busy, 0);
    chk("rst_rd", mem_rd_en, 0);
    chk("rst_addr", memory_address, 0);
    chk("rst_wr", write_data_array, 0);
    chk("rst_idx", word_idx, 0);
    chk("rst_tag", write_tag_array, 0);
    for (int c = 0; c < 14; c++) begin
      drive(tbl[c].miss, tbl[c].addr, 1, tbl[c].valid);
      chk($sformatf("t%0d_busy", c), fsm_busy, tbl[c].busy);
      chk($sformatf("t%0d_rd", c), mem_rd_en, tbl[c].rd);
      if (tbl[c].ac) chk($sformatf("t%0d_addr", c), memory_address, tbl[c].maddr);
      chk($sformatf("t%0d_wr", c), write_data_array, tbl[c].wr);
      if (tbl[c].ic) chk($sformatf("t%0d_idx", c), word_idx, tbl[c].idx);
      chk($sformatf("t%0d_tag", c), write_tag_array, tbl[c].tag);
    end
    t0 = tag_cnt;
    gap = 1;
    start(16'h123A);
    wait_done();
    chk("gap_tags", tag_cnt, t0 + 1);
    gap = 0;
    t0 = tag_cnt;
    start(16'h1236);
    for (int i = 0; i < 40 && tag_cnt == t0; i++) run(1, 16'h4000, 1, 0);
    chk("spur_tag", tag_cnt, t0 + 1);
    for (int i = 0; i < 3; i++) begin
      run(0, 16'h0, 1, 1);
      chk("spur_idle_busy", fsm_busy, 0);
    end
    chk("spur_no_tag", tag_cnt, t0 + 1);
    t0 = tag_cnt;
    start(16'h2468);
    for (int i = 0; i < 5; i++) run(0, 16'h0, 1, 0);
    run(0, 16'h0, 0, 0);
    flush();
    run(0, 16'h0, 1, 0);
    chk("abort_busy", fsm_busy, 0);
    chk("abort_rd", mem_rd_en, 0);
    chk("abort_wr", write_data_array, 0);
    chk("abort_idx", word_idx, 0);
    chk("abort_tag", tag_cnt, t0);
    start(16'h2468);
    wait_done();
    chk("refill_tag", tag_cnt, t0 + 1);
    t0 = tag_cnt;
    start(16'h1234);
    for (int i = 0; i < 40 && tag_cnt == t0; i++) run(0, 16'h0, 1, 0);
    start(16'hFFFE);
    wait_done();
    chk("b2b_tags", tag_cnt, t0 + 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
